tests_stall_gen: RTL and testbench
==================================

Name: tests_stall_gen

Overview:
- Parametrised, synthesisable stall generator for verification builds. Drives CHANNELS independent stall lines into pipeline handshakes: cache refill, AXI bridge, commit.
- Modes: off, LFSR-random with a percentage threshold, periodic duty-cycle, and random with a bounded stall run.
- Deterministic per-channel seeds make a failing run reproducible.
- A per-channel stall counter feeds difftest statistics.

Parameters:
- CHANNELS, 4, number of independent stall outputs (1..16)
- PERCENTAGE, 50, reset value of the random threshold (0..100)
- PERIOD, 8, periodic-mode period in cycles (>=2)
- DUTY, 2, stalled cycles per period in periodic mode (0..PERIOD)
- MAX_RUN, 8, max consecutive stall cycles in bounded mode (>=1)
- SEED, 32'h1ACE_C0DE, base LFSR seed; channel i seed = SEED ^ (i * 32'h9E37_79B9), forced nonzero
- CNT_W, 32, width of the stall statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- en_i  in  1  global enable; 0 forces all stalls low
- mode_i  in  2  0 OFF, 1 RANDOM, 2 PERIODIC, 3 BOUNDED
- pct_we_i  in  1  load new threshold from pct_i
- pct_i  in  7  new threshold; values >100 saturate to 100
- stall_o  out  CHANNELS  registered stall per channel
- stall_cnt_o  out  CHANNELS*CNT_W  per-channel count of cycles with stall_o=1

Behaviour:
Reset:
- stall_o=0, stall_cnt_o=0, LFSRs=seeds, threshold=PERCENTAGE, phase=0, run counters=0.
- Reset mid-operation restores exactly this state. The sequence after reset is identical to the first run.

Latency:
- stall_o is registered. The value at cycle t+1 is decided from the state and inputs sampled at edge t.
- Mode and threshold changes affect stall_o one cycle after the sampling edge.
- A pct_we_i write and a mode change in the same cycle both take effect together.

LFSR:
- 32-bit Galois, polynomial 0x8020_0003, one per channel.
- Advances once per cycle only while en_i=1 and mode is RANDOM or BOUNDED. Holds otherwise.

Random decision:
- r = lfsr[15:0]. stall_raw = ((r * 100) >> 16) < threshold. The multiply is 23 bits.
- threshold 0 never stalls; threshold 100 always stalls.

OFF, or en_i=0:
- stall_o=0. Phase and run counters clear to 0.

RANDOM:
- stall_o = stall_raw.

PERIODIC:
- Shared phase counter 0..PERIOD-1, wrapping to 0; advances while en_i=1 and mode=PERIODIC.
- stall_o[i] = (phase < DUTY) for all channels. DUTY=0 never stalls; DUTY=PERIOD always stalls.

BOUNDED:
- As RANDOM, with a per-channel run counter.
- If stall_o[i] has been 1 for MAX_RUN consecutive cycles, the next cycle is forced 0 regardless of stall_raw. The run counter then clears.
- The run counter clears on any 0 output and saturates at MAX_RUN.

Mode change:
- Entering PERIODIC starts at phase 0.
- LFSR state is retained across mode changes; it is not reseeded.

Statistics:
- stall_cnt_o[i] increments each cycle stall_o[i]=1 and saturates at all-ones.

Decomposition:
- Package tests_stall_pkg:
  - stall_mode_e enum (OFF, RANDOM, PERIODIC, BOUNDED)
  - LFSR_POLY and SEED_MIX constants
  - function lfsr_next(32b) -> 32b
  - function pct_hit(16b r, 7b thr) -> bit
- Sub-module tests_stall_lane: one channel holding its LFSR, run counter, stall register and statistics counter.
  - Generated CHANNELS times.
  - The top holds the threshold register, phase counter and mode decode.

Test Plan:
- Reset then mode=RANDOM, pct_i=0 written, 1000 cycles -> stall_o==0 every cycle, stall_cnt_o all 0.
- mode=BOUNDED, threshold 100, MAX_RUN=8 -> each channel repeats 8 cycles of 1 then 1 cycle of 0; stall_cnt after 90 cycles == 80.
- mode=PERIODIC, PERIOD=5, DUTY=2 -> stall_o pattern 1,1,0,0,0 repeating on all channels from cycle 1 after entry; drop en_i for 3 cycles -> 0s, then restarts at phase 0.
- mode=RANDOM, threshold 50, 10000 cycles -> each channel's stall fraction within 47%..53%; channel sequences pairwise different.
- Run RANDOM 200 cycles and record the trace; assert rst mid-cycle, release, rerun -> bit-identical trace, and stall_o=0 while rst=1.
- pct_i=120 written -> threshold saturates to 100, always stall in RANDOM; write 30 -> the change is visible exactly one cycle after pct_we_i.

Source files
------------

// File: rtl/tests_stall_pkg.sv
// Shared types and helpers for the verification stall generator.
// Holds the mode encoding, LFSR step and the percentage-hit decision.
package tests_stall_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_RANDOM   = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_BOUNDED  = 2'd3
    } stall_mode_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] SEED_MIX  = 32'h9E37_79B9;
    localparam logic [6:0]  PCT_MAX   = 7'd100;

    // Right-shifting Galois step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Scale r into 0..99 and compare against the threshold.
    function automatic logic pct_hit(input logic [15:0] r, input logic [6:0] thr);
        logic [22:0] prod;
        prod = 23'(r) * 23'd100;
        return prod[22:16] < thr;
    endfunction

    function automatic logic [6:0] pct_sat(input logic [6:0] p);
        return (p > PCT_MAX) ? PCT_MAX : p;
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned idx);
        logic [31:0] s;
        s = base ^ (32'(idx) * SEED_MIX);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/tests_stall_lane.sv
// One stall channel: private LFSR, bounded-run counter, stall register
// and saturating statistics counter.
module tests_stall_lane
    import tests_stall_pkg::*;
#(
    parameter logic [31:0] SEED_VAL = 32'h1,
    parameter int          MAX_RUN  = 8,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rand_en,
    input  logic             bounded,
    input  logic             per_en,
    input  logic             per_stall,
    input  logic [6:0]       thr,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);

    logic [31:0]      lfsr_q, lfsr_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             stall_d;
    logic             hit;

    assign hit = pct_hit(lfsr_q[15:0], thr);

    always_comb begin
        lfsr_d  = lfsr_q;
        run_d   = '0;
        stall_d = 1'b0;
        if (rand_en) begin
            lfsr_d = lfsr_next(lfsr_q);
            // A full run forces one idle cycle regardless of the draw.
            if (bounded && run_q == RUN_W'(MAX_RUN)) begin
                stall_d = 1'b0;
            end else begin
                stall_d = hit;
                run_d   = (bounded && hit) ? run_q + RUN_W'(1) : '0;
            end
        end else if (per_en) begin
            stall_d = per_stall;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q    <= SEED_VAL;
            run_q     <= '0;
            stall     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            run_q  <= run_d;
            stall  <= stall_d;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tests_stall_gen.sv
// Stall generator top: threshold register, shared periodic phase and mode
// decode, driving CHANNELS independent stall lanes.
module tests_stall_gen
    import tests_stall_pkg::*;
#(
    parameter int          CHANNELS   = 4,
    parameter int          PERCENTAGE = 50,
    parameter int          PERIOD     = 8,
    parameter int          DUTY       = 2,
    parameter int          MAX_RUN    = 8,
    parameter logic [31:0] SEED       = 32'h1ACE_C0DE,
    parameter int          CNT_W      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_i,
    input  logic [1:0]                      mode_i,
    input  logic                            pct_we_i,
    input  logic [6:0]                      pct_i,
    output logic [CHANNELS-1:0]             stall_o,
    output logic [CHANNELS-1:0][CNT_W-1:0]  stall_cnt_o
);

    localparam int              PH_W   = $clog2(PERIOD);
    localparam logic [PH_W:0]   DUTY_V = (PH_W + 1)'(DUTY);

    stall_mode_e     mode;
    logic [6:0]      thr_q, thr_eff;
    logic [PH_W-1:0] phase_q;
    logic            rand_en, bounded, per_en, per_stall;

    assign mode    = stall_mode_e'(mode_i);
    assign rand_en = en_i && (mode == MODE_RANDOM || mode == MODE_BOUNDED);
    assign bounded = (mode == MODE_BOUNDED);
    assign per_en  = en_i && (mode == MODE_PERIODIC);
    // A write is bypassed so it lands on the same edge as a mode change.
    assign thr_eff   = pct_we_i ? pct_sat(pct_i) : thr_q;
    assign per_stall = ({1'b0, phase_q} < DUTY_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q   <= pct_sat(7'(PERCENTAGE));
            phase_q <= '0;
        end else begin
            if (pct_we_i)
                thr_q <= pct_sat(pct_i);
            if (!per_en)
                phase_q <= '0;
            else if (phase_q == PH_W'(PERIOD - 1))
                phase_q <= '0;
            else
                phase_q <= phase_q + PH_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        tests_stall_lane #(
            .SEED_VAL (lane_seed(SEED, i)),
            .MAX_RUN  (MAX_RUN),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .rand_en   (rand_en),
            .bounded   (bounded),
            .per_en    (per_en),
            .per_stall (per_stall),
            .thr       (thr_eff),
            .stall     (stall_o[i]),
            .stall_cnt (stall_cnt_o[i])
        );
    end

endmodule

// File: tb/tb_tests_stall_gen.sv
// Self-checking bench for tests_stall_gen: vector table, scoreboarded
// deterministic runs, random statistics and reset replay.
module tb_tests_stall_gen;

    localparam int CH    = 4;
    localparam int CNT_W = 32;
    localparam logic [1:0] M_OFF = 2'd0, M_RND = 2'd1, M_PER = 2'd2, M_BND = 2'd3;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      en = 1'b0;
    logic [1:0]                mode = M_OFF;
    logic                      pct_we = 1'b0;
    logic [6:0]                pct = 7'd0;
    logic [CH-1:0]             stall;
    logic [CH-1:0][CNT_W-1:0]  cnt;

    int checks = 0;
    int errors = 0;
    logic [CH-1:0] exp_q[$];

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       we;
        logic [6:0] pct;
        logic       exp;
    } vec_t;
    vec_t tbl[$];

    logic [CH-1:0] tr1[200];
    int            ones[CH];

    tests_stall_gen #(
        .CHANNELS(CH), .PERCENTAGE(50), .PERIOD(5), .DUTY(2),
        .MAX_RUN(8), .SEED(32'h1ACE_C0DE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en), .mode_i(mode),
        .pct_we_i(pct_we), .pct_i(pct),
        .stall_o(stall), .stall_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // One clock: drive at negedge, sample #1 after the posedge.
    task automatic cyc(input logic e, input logic [1:0] m, input logic we, input logic [6:0] p,
                       input logic chk, input logic [CH-1:0] exp, input string nm);
        logic [CH-1:0] want;
        @(negedge clk);
        en = e; mode = m; pct_we = we; pct = p;
        if (chk) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (chk) begin
            want = exp_q.pop_front();
            check(nm, 64'(stall), 64'(want));
        end
    endtask

    // Reset asserted mid-cycle; inputs idle so release does not advance state.
    task automatic do_reset();
        @(posedge clk);
        #2;
        en = 1'b0; pct_we = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        for (int i = 0; i < CH; i++) check("rst_cnt", 64'(cnt[i]), 64'd0);
        repeat (2) @(negedge clk);
        check("rst_hold", 64'(stall), 64'd0);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic e, input logic [1:0] m, input logic we,
                                input logic [6:0] p, input logic x);
        vec_t v;
        v.en = e; v.mode = m; v.we = we; v.pct = p; v.exp = x;
        return v;
    endfunction

    initial begin
        // Vector table: threshold extremes, periodic pattern, enable drop, mode changes.
        tbl.push_back(mk(1, M_RND, 1, 7'd120, 1));
        tbl.push_back(mk(1, M_RND, 0, 7'd0,   1));
        tbl.push_back(mk(1, M_RND, 0, 7'd0,   1));
        tbl.push_back(mk(1, M_RND, 1, 7'd0,   0));
        tbl.push_back(mk(1, M_RND, 0, 7'd0,   0));
        tbl.push_back(mk(1, M_RND, 1, 7'd100, 1));
        for (int k = 0; k < 8; k++) tbl.push_back(mk(1, M_PER, 0, 0, (k % 5) < 2));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, M_PER, 0, 0, 0));
        for (int k = 0; k < 6; k++) tbl.push_back(mk(1, M_PER, 0, 0, (k % 5) < 2));
        tbl.push_back(mk(1, M_OFF, 0, 0,      0));
        tbl.push_back(mk(1, M_RND, 1, 7'd0,   0));
        tbl.push_back(mk(1, M_PER, 0, 0,      1));
        tbl.push_back(mk(1, M_PER, 0, 0,      1));
        tbl.push_back(mk(1, M_RND, 1, 7'd100, 1));
        tbl.push_back(mk(1, M_PER, 0, 0,      1));
        tbl.push_back(mk(1, M_PER, 0, 0,      1));
        tbl.push_back(mk(1, M_PER, 0, 0,      0));

        do_reset();

        // Threshold 0 never stalls.
        cyc(1, M_RND, 1, 7'd0, 1, '0, "thr0");
        for (int k = 0; k < 1000; k++) cyc(1, M_RND, 0, 7'd0, 1, '0, "thr0");
        for (int i = 0; i < CH; i++) check("thr0_cnt", 64'(cnt[i]), 64'd0);

        foreach (tbl[k])
            cyc(tbl[k].en, tbl[k].mode, tbl[k].we, tbl[k].pct, 1, {CH{tbl[k].exp}}, "table");

        // Threshold 30 statistics.
        cyc(1, M_RND, 1, 7'd30, 0, '0, "");
        for (int i = 0; i < CH; i++) ones[i] = 0;
        for (int k = 0; k < 2000; k++) begin
            cyc(1, M_RND, 0, 7'd0, 0, '0, "");
            for (int i = 0; i < CH; i++) ones[i] += int'(stall[i]);
        end
        for (int i = 0; i < CH; i++)
            check("pct30_frac", 64'(ones[i] >= 500 && ones[i] <= 700), 64'd1);

        // Bounded run at threshold 100: 8 stalled cycles then one idle.
        do_reset();
        cyc(1, M_BND, 1, 7'd100, 1, '1, "bounded");
        for (int k = 2; k <= 90; k++)
            cyc(1, M_BND, 0, 7'd0, 1, (k % 9 == 0) ? '0 : '1, "bounded");
        for (int i = 0; i < CH; i++) check("bounded_cnt", 64'(cnt[i]), 64'd80);

        // Random at reset threshold 50.
        do_reset();
        for (int i = 0; i < CH; i++) ones[i] = 0;
        for (int k = 0; k < 10000; k++) begin
            cyc(1, M_RND, 0, 7'd0, 0, '0, "");
            if (k < 200) tr1[k] = stall;
            for (int i = 0; i < CH; i++) ones[i] += int'(stall[i]);
        end
        for (int i = 0; i < CH; i++)
            check("pct50_frac", 64'(ones[i] >= 4700 && ones[i] <= 5300), 64'd1);
        for (int i = 0; i < CH; i++)
            for (int j = i + 1; j < CH; j++) begin
                logic [199:0] a, b;
                for (int k = 0; k < 200; k++) begin a[k] = tr1[k][i]; b[k] = tr1[k][j]; end
                check("chan_distinct", 64'(a != b), 64'd1);
            end

        // Mid-operation reset replays the same sequence.
        do_reset();
        for (int k = 0; k < 200; k++) cyc(1, M_RND, 0, 7'd0, 1, tr1[k], "replay");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
